// File: rtl/tetris_pkg.sv
// Shared constants, error codes and FSM encoding for the TETRIS round driver.
package tetris_pkg;

   // Board geometry; the core reports the playfield as one flat vector
   localparam int BOARD_W    = 6;
   localparam int BOARD_H    = 12;
   localparam int BOARD_BITS = BOARD_W * BOARD_H;
   localparam logic [BOARD_BITS-1:0] BOARD_EMPTY = '0;

   // Piece types as understood by the core
   localparam logic [2:0] PIECE_0 = 3'd0;
   localparam logic [2:0] PIECE_1 = 3'd1;
   localparam logic [2:0] PIECE_2 = 3'd2;
   localparam logic [2:0] PIECE_3 = 3'd3;
   localparam logic [2:0] PIECE_4 = 3'd4;
   localparam logic [2:0] PIECE_5 = 3'd5;
   localparam logic [2:0] PIECE_6 = 3'd6;
   localparam logic [2:0] PIECE_7 = 3'd7;

   // Round termination codes
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_UNSOL   = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Rightmost legal leftmost-column for each piece so it stays on the board
   function automatic logic [2:0] maxpos(input logic [2:0] t);
      logic [2:0] m;
      case (t)
         PIECE_0: m = 3'd4;
         PIECE_1: m = 3'd5;
         PIECE_2: m = 3'd2;
         PIECE_3: m = 3'd4;
         PIECE_4: m = 3'd3;
         PIECE_5: m = 3'd4;
         PIECE_6: m = 3'd3;
         PIECE_7: m = 3'd4;
         default: m = 3'd0;
      endcase
      return m;
   endfunction

   // Saturate a raw random column to the piece's legal range
   function automatic logic [2:0] clamp_pos(input logic [2:0] t, input logic [2:0] raw);
      return (raw > maxpos(t)) ? maxpos(t) : raw;
   endfunction

endpackage

// File: rtl/tetris_round_driver_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying random pieces.
module tetris_lfsr16
   import tetris_pkg::*;
#(
   parameter logic [15:0] SEED_DEF = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        en_i,
   input  logic [15:0] seed_i,
   output logic [15:0] out_o
);

   logic [15:0] lfsr_q, lfsr_d;

   // Load wins over step; a zero seed would lock the register, so substitute the default
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i)
         lfsr_d = (seed_i == 16'h0000) ? SEED_DEF : seed_i;
      else if (en_i)
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED_DEF;
      else     lfsr_q <= lfsr_d;
   end

   assign out_o = lfsr_q;

endmodule

// File: rtl/tetris_round_driver.sv
// Drives one round of random placements into the TETRIS core and collects results.
module tetris_round_driver
   import tetris_pkg::*;
#(
   parameter int unsigned ROUND_LEN = 16,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [15:0] SEED_DEF  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [15:0]           seed_i,
   output logic                  in_valid_o,
   output logic [2:0]            tetrominoes_o,
   output logic [2:0]            position_o,
   input  logic                  score_valid_i,
   input  logic                  fail_i,
   input  logic [3:0]            score_i,
   input  logic                  tetris_valid_i,
   input  logic [BOARD_BITS-1:0] tetris_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            err_o,
   output logic                  fail_seen_o,
   output logic [3:0]            final_score_o,
   output logic [4:0]            pieces_sent_o,
   output logic [BOARD_BITS-1:0] board_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   // Last WAIT cycle is TIMEOUT-1 cycles after in_valid, so DONE lands exactly TIMEOUT after it
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 2);
   localparam logic [4:0]    LAST_PIECE = 5'(ROUND_LEN);

   state_e                state_q, state_d;
   logic [2:0]            type_q, type_d;
   logic [2:0]            pos_q, pos_d;
   logic [4:0]            pieces_q, pieces_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [1:0]            err_q, err_d;
   logic                  fail_q, fail_d;
   logic [3:0]            score_q, score_d;
   logic [BOARD_BITS-1:0] board_q, board_d;

   logic        lfsr_load, lfsr_en;
   logic [15:0] lfsr;
   logic        lfsr_unused;
   logic        resp;

   tetris_lfsr16 #(.SEED_DEF(SEED_DEF)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load_i (lfsr_load),
      .en_i   (lfsr_en),
      .seed_i (seed_i),
      .out_o  (lfsr)
   );

   // Only the low six bits choose the piece; the rest just feed the shift
   assign lfsr_unused = ^lfsr[15:6];
   assign resp        = score_valid_i | tetris_valid_i;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and result update; any response outside WAIT is a protocol error
   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      pos_d     = pos_q;
      pieces_d  = pieces_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      fail_d    = fail_q;
      score_d   = score_q;
      board_d   = board_q;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (resp) begin
               err_d = ERR_UNSOL;
            end else if (start_i) begin
               lfsr_load = 1'b1;
               pieces_d  = '0;
               err_d     = ERR_NONE;
               fail_d    = 1'b0;
               score_d   = '0;
               board_d   = BOARD_EMPTY;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            type_d = lfsr[2:0];
            pos_d  = clamp_pos(lfsr[2:0], lfsr[5:3]);
            if (resp) begin
               err_d   = ERR_UNSOL;
               state_d = ST_DONE;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // The strobe goes out this cycle regardless, so always account for it
            pieces_d = pieces_q + 5'd1;
            lfsr_en  = 1'b1;
            tmo_d    = '0;
            if (resp) begin
               err_d   = ERR_UNSOL;
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (score_valid_i) begin
               score_d = score_i;
               if (tetris_valid_i) begin
                  board_d = tetris_i;
                  fail_d  = fail_i;
                  state_d = ST_DONE;
               end else if (fail_i) begin
                  // A failing core must also deliver its board
                  fail_d  = 1'b1;
                  err_d   = ERR_UNSOL;
                  state_d = ST_DONE;
               end else if (pieces_q == LAST_PIECE) begin
                  err_d   = ERR_OVERRUN;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
               end
            end else if (tetris_valid_i) begin
               err_d   = ERR_UNSOL;
               state_d = ST_DONE;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (resp) err_d = ERR_UNSOL;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Piece, counters and round results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         type_q   <= '0;
         pos_q    <= '0;
         pieces_q <= '0;
         tmo_q    <= '0;
         err_q    <= ERR_NONE;
         fail_q   <= 1'b0;
         score_q  <= '0;
         board_q  <= BOARD_EMPTY;
      end else begin
         type_q   <= type_d;
         pos_q    <= pos_d;
         pieces_q <= pieces_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         score_q  <= score_d;
         board_q  <= board_d;
      end
   end

   // Strobe and piece are decoded from state so reset drops them immediately
   assign in_valid_o    = (state_q == ST_SEND);
   assign tetrominoes_o = in_valid_o ? type_q : 3'd0;
   assign position_o    = in_valid_o ? pos_q : 3'd0;
   assign busy_o        = (state_q == ST_LOAD) || (state_q == ST_SEND) || (state_q == ST_WAIT);
   assign done_o        = (state_q == ST_DONE);
   assign err_o         = err_q;
   assign fail_seen_o   = fail_q;
   assign final_score_o = score_q;
   assign pieces_sent_o = pieces_q;
   assign board_o       = board_q;

endmodule
